// File: rtl/wb_cmd_master.sv
// ---------------------------------------------------------------------------
// wb_cmd_master
//   Wishbone classic (non-pipelined) initiator. Turns one valid/ready command
//   (we/sel/adr/dat) into a single Wishbone read or write cycle and returns
//   the outcome on a valid/ready response stream. A per-transaction ack
//   timeout stops a dead or tristated slave from hanging the initiator.
//
// Handshake rule for both streams: a beat transfers on the rising clock edge
// where valid && ready are both high. Once raised, valid stays high and the
// payload stays stable until that edge. ready never depends on valid.
//
// Ports
//   wb_clk_i, wb_rst_n_i        clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o   command handshake
//   cmd_we/sel/adr/dat_i        command payload
//   rsp_valid_o / rsp_ready_i   response handshake
//   rsp_dat_o, rsp_err_o        read data (0 for writes/errors), timeout flag
//   wbm_*                       Wishbone initiator signals
//   busy_o                      high whenever the FSM is not idle
//   timeout_cnt_o               saturating count of timed-out transactions
//   dbg_state_o                 current FSM state encoding
// ---------------------------------------------------------------------------
module wb_cmd_master #(
  parameter  int ADDR_W         = 32,
  parameter  int DATA_W         = 32,
  parameter  int TIMEOUT_CYCLES = 255,
  parameter  int CNT_W          = 16,
  localparam int SEL_W          = DATA_W / 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_n_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [SEL_W-1:0]  cmd_sel_i,
  input  logic [ADDR_W-1:0] cmd_adr_i,
  input  logic [DATA_W-1:0] cmd_dat_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_dat_o,
  output logic              rsp_err_o,
  output logic              wbm_cyc_o,
  output logic              wbm_stb_o,
  output logic              wbm_we_o,
  output logic [SEL_W-1:0]  wbm_sel_o,
  output logic [ADDR_W-1:0] wbm_adr_o,
  output logic [DATA_W-1:0] wbm_dat_o,
  input  logic              wbm_ack_i,
  input  logic [DATA_W-1:0] wbm_dat_i,
  output logic              busy_o,
  output logic [CNT_W-1:0]  timeout_cnt_o,
  output logic [1:0]        dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  // The wait counter only has to reach TIMEOUT_CYCLES-1.
  localparam int WAIT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  state_t              r_state;
  logic                r_cyc;
  logic                r_we;
  logic [SEL_W-1:0]    r_sel;
  logic [ADDR_W-1:0]   r_adr;
  logic [DATA_W-1:0]   r_dat;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_dat;
  logic                r_rsp_err;
  logic [WAIT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]    r_tmo_cnt;

  logic                w_timeout;

  // Threshold reached this cycle; an ack in the same cycle takes priority.
  assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_wait_cnt == WAIT_LAST);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state     <= S_IDLE;
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_sel       <= '0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
      r_wait_cnt  <= '0;
      r_tmo_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            r_we       <= cmd_we_i;
            r_sel      <= cmd_sel_i;
            r_adr      <= cmd_adr_i;
            r_dat      <= cmd_dat_i;
            r_cyc      <= 1'b1;
            r_wait_cnt <= '0;
            r_state    <= S_BUS;
          end
        end

        S_BUS: begin
          if (wbm_ack_i) begin
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_dat   <= r_we ? '0 : wbm_dat_i;
            r_state     <= S_RESP;
          end else if (w_timeout) begin
            r_cyc       <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b1;
            r_rsp_dat   <= '0;
            if (r_tmo_cnt != '1) begin
              r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end
            r_state     <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        S_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_cyc       <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready_o   = (r_state == S_IDLE);
  assign busy_o        = (r_state != S_IDLE);
  assign dbg_state_o   = r_state;

  assign wbm_cyc_o     = r_cyc;
  assign wbm_stb_o     = r_cyc;
  assign wbm_we_o      = r_we;
  assign wbm_sel_o     = r_sel;
  assign wbm_adr_o     = r_adr;
  assign wbm_dat_o     = r_dat;

  assign rsp_valid_o   = r_rsp_valid;
  assign rsp_dat_o     = r_rsp_dat;
  assign rsp_err_o     = r_rsp_err;
  assign timeout_cnt_o = r_tmo_cnt;

endmodule

// File: tb/tb_wb_cmd_master.sv
// ---------------------------------------------------------------------------
// tb_wb_cmd_master
//   Directed bench for wb_cmd_master with TIMEOUT_CYCLES = 8. Inputs change
//   and outputs are sampled on the falling clock edge; the DUT acts on the
//   rising edge.
// ---------------------------------------------------------------------------
module tb_wb_cmd_master;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int SEL_W  = 4;
  localparam int TMO    = 8;
  localparam int CNT_W  = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_we;
  logic [SEL_W-1:0]  cmd_sel;
  logic [ADDR_W-1:0] cmd_adr;
  logic [DATA_W-1:0] cmd_dat;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_dat;
  logic              rsp_err;
  logic              wbm_cyc;
  logic              wbm_stb;
  logic              wbm_we;
  logic [SEL_W-1:0]  wbm_sel;
  logic [ADDR_W-1:0] wbm_adr;
  logic [DATA_W-1:0] wbm_dat_o;
  logic              wbm_ack;
  logic [DATA_W-1:0] wbm_dat_i;
  logic              busy;
  logic [CNT_W-1:0]  tmo_cnt;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  wb_cmd_master #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .TIMEOUT_CYCLES(TMO),
    .CNT_W(CNT_W)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_n_i(rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_we_i(cmd_we),
    .cmd_sel_i(cmd_sel),
    .cmd_adr_i(cmd_adr),
    .cmd_dat_i(cmd_dat),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err),
    .wbm_cyc_o(wbm_cyc),
    .wbm_stb_o(wbm_stb),
    .wbm_we_o(wbm_we),
    .wbm_sel_o(wbm_sel),
    .wbm_adr_o(wbm_adr),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack),
    .wbm_dat_i(wbm_dat_i),
    .busy_o(busy),
    .timeout_cnt_o(tmo_cnt),
    .dbg_state_o(dbg_state)
  );

  // ---------------- driver tasks ----------------
  // Offer a command at the current falling edge; returns at the falling edge
  // after the accepting rising edge, with cmd_valid dropped.
  task automatic send_cmd(input logic we, input logic [SEL_W-1:0] sel,
                          input logic [ADDR_W-1:0] adr, input logic [DATA_W-1:0] dat);
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_ready_before_send: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_sel   = sel;
    cmd_adr   = adr;
    cmd_dat   = dat;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Slave model: counts cycles with cyc high and acks on the ack_at-th one
  // (0 = never ack). Checks the bus fields on every cyc-high cycle.
  task automatic run_bus(input int ack_at, input logic [DATA_W-1:0] rd_dat,
                         input logic exp_we, input logic [SEL_W-1:0] exp_sel,
                         input logic [ADDR_W-1:0] exp_adr, input logic [DATA_W-1:0] exp_dat,
                         output int n_cyc);
    logic bad;
    bad   = 1'b0;
    n_cyc = 0;
    for (int i = 0; i < 50; i++) begin
      if (!wbm_cyc) break;
      n_cyc++;
      if (wbm_stb !== 1'b1 || wbm_we !== exp_we || wbm_sel !== exp_sel ||
          wbm_adr !== exp_adr || (exp_we && wbm_dat_o !== exp_dat))
        bad = 1'b1;
      wbm_ack   = (n_cyc == ack_at);
      wbm_dat_i = (n_cyc == ack_at) ? rd_dat : 32'hFFFF_FFFF;
      @(negedge clk);
    end
    wbm_ack   = 1'b0;
    wbm_dat_i = 32'hFFFF_FFFF;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bus_fields: stb=%b we=%b sel=%h adr=%h dat=%h want we=%b sel=%h adr=%h dat=%h",
               wbm_stb, wbm_we, wbm_sel, wbm_adr, wbm_dat_o, exp_we, exp_sel, exp_adr, exp_dat);
    end
  endtask

  // Accept the pending response with a one-cycle rsp_ready pulse.
  task automatic take_rsp();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rsp_release: valid=%b cmd_ready=%b busy=%b want 0 1 0",
               rsp_valid, cmd_ready, busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_sel   = '0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    rsp_ready = 1'b0;
    wbm_ack   = 1'b0;
    wbm_dat_i = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (wbm_cyc !== 1'b0 || wbm_stb !== 1'b0) begin
      errors++;
      $display("FAIL reset_bus: cyc=%b stb=%b want 0 0", wbm_cyc, wbm_stb);
    end
    checks++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_ctrl: cmd_ready=%b busy=%b state=%0d want 1 0 0",
               cmd_ready, busy, dbg_state);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_dat !== 32'h0 || tmo_cnt !== 16'h0) begin
      errors++;
      $display("FAIL reset_rsp: valid=%b err=%b dat=%h tmo=%0d want 0 0 0 0",
               rsp_valid, rsp_err, rsp_dat, tmo_cnt);
    end
  endtask

  task automatic test_write_zero_wait();
    int n;
    send_cmd(1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF);
    run_bus(1, 32'hFFFF_FFFF, 1'b1, 4'hF, 32'h3000_0004, 32'hDEAD_BEEF, n);
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL write_cyc_len: got %0d want 1", n);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h0) begin
      errors++;
      $display("FAIL write_rsp: valid=%b err=%b dat=%h want 1 0 00000000",
               rsp_valid, rsp_err, rsp_dat);
    end
    take_rsp();
  endtask

  task automatic test_read_wait();
    int n;
    send_cmd(1'b0, 4'hF, 32'h3000_0008, 32'h0);
    run_bus(4, 32'h1234_5678, 1'b0, 4'hF, 32'h3000_0008, 32'h0, n);
    checks++;
    if (n != 4) begin
      errors++;
      $display("FAIL read_cyc_len: got %0d want 4", n);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h1234_5678) begin
      errors++;
      $display("FAIL read_rsp: valid=%b err=%b dat=%h want 1 0 12345678",
               rsp_valid, rsp_err, rsp_dat);
    end
    take_rsp();
  endtask

  task automatic test_timeout();
    int n;
    for (int k = 1; k <= 2; k++) begin
      send_cmd(1'b0, 4'h1, 32'h3000_0100, 32'h0);
      run_bus(0, 32'h0, 1'b0, 4'h1, 32'h3000_0100, 32'h0, n);
      checks++;
      if (n != TMO) begin
        errors++;
        $display("FAIL timeout_cyc_len: got %0d want %0d", n, TMO);
      end
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_dat !== 32'h0 || tmo_cnt !== 16'(k)) begin
        errors++;
        $display("FAIL timeout_rsp: valid=%b err=%b dat=%h tmo=%0d want 1 1 00000000 %0d",
                 rsp_valid, rsp_err, rsp_dat, tmo_cnt, k);
      end
      take_rsp();
    end
  endtask

  task automatic test_ack_on_timeout();
    int n;
    send_cmd(1'b0, 4'hF, 32'h3000_0200, 32'h0);
    run_bus(TMO, 32'hA5A5_A5A5, 1'b0, 4'hF, 32'h3000_0200, 32'h0, n);
    checks++;
    if (n != TMO) begin
      errors++;
      $display("FAIL edge_ack_cyc_len: got %0d want %0d", n, TMO);
    end
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'hA5A5_A5A5 || tmo_cnt !== 16'd2) begin
      errors++;
      $display("FAIL edge_ack_rsp: valid=%b err=%b dat=%h tmo=%0d want 1 0 a5a5a5a5 2",
               rsp_valid, rsp_err, rsp_dat, tmo_cnt);
    end
    take_rsp();
  endtask

  task automatic test_backpressure();
    int n;
    send_cmd(1'b0, 4'hF, 32'h3000_0300, 32'h0);
    run_bus(2, 32'h0BAD_F00D, 1'b0, 4'hF, 32'h3000_0300, 32'h0, n);
    // Offer the next command while the response is stalled.
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_sel   = 4'h3;
    cmd_adr   = 32'h3000_0010;
    cmd_dat   = 32'h55AA_55AA;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h0BAD_F00D ||
          cmd_ready !== 1'b0 || wbm_cyc !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b err=%b dat=%h cmd_ready=%b cyc=%b want 1 0 0badf00d 0 0",
                 c, rsp_valid, rsp_err, rsp_dat, cmd_ready, wbm_cyc);
      end
      // Spurious ack while the response is pending.
      wbm_ack   = (c == 2);
      wbm_dat_i = 32'hFFFF_FFFF;
      @(negedge clk);
    end
    wbm_ack = 1'b0;
    checks++;
    if (rsp_dat !== 32'h0BAD_F00D || rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_after_spurious: valid=%b dat=%h want 1 0badf00d", rsp_valid, rsp_dat);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || wbm_cyc !== 1'b0) begin
      errors++;
      $display("FAIL bp_handshake: valid=%b cmd_ready=%b cyc=%b want 0 1 0",
               rsp_valid, cmd_ready, wbm_cyc);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    run_bus(1, 32'hFFFF_FFFF, 1'b1, 4'h3, 32'h3000_0010, 32'h55AA_55AA, n);
    checks++;
    if (n != 1 || rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_dat !== 32'h0) begin
      errors++;
      $display("FAIL bp_next_cmd: cyc_len=%0d valid=%b err=%b dat=%h want 1 1 0 00000000",
               n, rsp_valid, rsp_err, rsp_dat);
    end
    take_rsp();
  endtask

  task automatic test_reset_mid_bus();
    int n;
    send_cmd(0, 4'hF, 32'h3000_0400, 32'h0);
    repeat (2) @(negedge clk);
    checks++;
    if (wbm_cyc !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre_cyc: got %b want 1", wbm_cyc);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (wbm_cyc !== 1'b0 || wbm_stb !== 1'b0) begin
      errors++;
      $display("FAIL rst_async_drop: cyc=%b stb=%b want 0 0", wbm_cyc, wbm_stb);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || tmo_cnt !== 16'h0 || wbm_cyc !== 1'b0) begin
      errors++;
      $display("FAIL rst_after_release: valid=%b cmd_ready=%b tmo=%0d cyc=%b want 0 1 0 0",
               rsp_valid, cmd_ready, tmo_cnt, wbm_cyc);
    end
    // The initiator must be usable again straight after reset.
    send_cmd(1'b0, 4'hF, 32'h3000_0500, 32'h0);
    run_bus(1, 32'hCAFE_0001, 1'b0, 4'hF, 32'h3000_0500, 32'h0, n);
    checks++;
    if (n != 1 || rsp_valid !== 1'b1 || rsp_dat !== 32'hCAFE_0001) begin
      errors++;
      $display("FAIL rst_recover: cyc_len=%0d valid=%b dat=%h want 1 1 cafe0001",
               n, rsp_valid, rsp_dat);
    end
    take_rsp();
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_timeout();
    test_ack_on_timeout();
    test_backpressure();
    test_reset_mid_bus();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
